// File: rtl/sprite_field_pkg.sv
// Shared key codes, colours and FSM state type for the sprite field game core.
package sprite_field_pkg;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [7:0] KEY_LEFT    = 8'h1C;
  localparam logic [7:0] KEY_RIGHT   = 8'h23;
  localparam logic [7:0] KEY_UP      = 8'h1D;
  localparam logic [7:0] KEY_DOWN    = 8'h1B;
  localparam logic [7:0] KEY_RESTART = 8'h29;
  localparam logic [7:0] KEY_ESC     = 8'h76;

  localparam logic [11:0] COL_OFF        = 12'h000;
  localparam logic [11:0] COL_PLAYER     = 12'h0F0;
  localparam logic [11:0] COL_PLAYER_HIT = 12'hF00;
  localparam logic [11:0] COL_OBST       = 12'hFFF;
  localparam logic [11:0] COL_BG         = 12'h008;
  localparam logic [11:0] COL_BORDER     = 12'hFF0;

  localparam int BORDER_W = 4;

endpackage

// File: rtl/obstacle_unit.sv
// One horizontally scrolling obstacle: x register with move/wrap/reload, plus
// pixel-hit and player-overlap flags. Its y position is fixed by its index.
module obstacle_unit #(
  parameter int IDX        = 0,
  parameter int SCREEN_W   = 640,
  parameter int OW         = 16,
  parameter int OH         = 16,
  parameter int PW         = 16,
  parameter int PH         = 16,
  parameter int OBST_SPEED = 2,
  parameter int OBST_X0    = 320,
  parameter int OBST_GAP   = 80,
  parameter int OBST_Y0    = 64,
  parameter int OBST_YSTEP = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_i,
  input  logic       reload_i,
  input  logic [9:0] px_i,
  input  logic [8:0] py_i,
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  output logic       hit_o,
  output logic       collide_o
);

  localparam logic [9:0] OX_INIT = 10'(OBST_X0 + IDX * OBST_GAP);
  localparam logic [9:0] OX_WRAP = 10'(SCREEN_W - OW);
  localparam logic [9:0] SPEED   = 10'(OBST_SPEED);
  localparam logic [9:0] OY_T    = 10'(OBST_Y0 + IDX * OBST_YSTEP);
  localparam logic [9:0] OY_B    = 10'(OBST_Y0 + IDX * OBST_YSTEP + OH - 1);

  logic [9:0]  ox_q, ox_d;
  logic [10:0] ox_l, ox_r, px_l, px_r, x_e;
  logic [9:0]  py_t, py_b, y_e;

  always_comb begin
    ox_d = ox_q;
    if (reload_i)    ox_d = OX_INIT;
    else if (move_i) ox_d = (ox_q < SPEED) ? OX_WRAP : ox_q - SPEED;
  end

  always_ff @(posedge clk) begin
    if (reset) ox_q <= OX_INIT;
    else       ox_q <= ox_d;
  end

  // Widened by one bit so box right/bottom edges never wrap.
  assign ox_l = {1'b0, ox_q};
  assign ox_r = ox_l + 11'(OW - 1);
  assign px_l = {1'b0, px_i};
  assign px_r = px_l + 11'(PW - 1);
  assign py_t = {1'b0, py_i};
  assign py_b = py_t + 10'(PH - 1);
  assign x_e  = {1'b0, x_i};
  assign y_e  = {1'b0, y_i};

  assign hit_o     = (x_e >= ox_l) && (x_e <= ox_r) && (y_e >= OY_T) && (y_e <= OY_B);
  assign collide_o = (px_l <= ox_r) && (ox_l <= px_r) && (py_t <= OY_B) && (OY_T <= py_b);

endmodule

// File: rtl/sprite_field_engine.sv
// Game core: keyboard-driven player and N_OBST scrolling obstacles, per-pixel RGB and collision halt.
// Build macro SPRITE_FIELD_BORDER_EN adds a 4-pixel border, shrinks the player clamp and enables Esc-to-halt.
module sprite_field_engine
  import sprite_field_pkg::*;
#(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int PW         = 16,
  parameter int PH         = 16,
  parameter int STEP       = 4,
  parameter int N_OBST     = 4,
  parameter int OW         = 16,
  parameter int OH         = 16,
  parameter int OBST_SPEED = 2,
  parameter int OBST_X0    = 320,
  parameter int OBST_GAP   = 80,
  parameter int OBST_Y0    = 64,
  parameter int OBST_YSTEP = 96,
  parameter int INIT_X     = 20,
  parameter int INIT_Y     = 232
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vs,
  input  logic [9:0]  keyboard,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  output logic [11:0] RGB,
  output logic        stop
);

`ifdef SPRITE_FIELD_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif
  localparam int          BRD  = BORDER_EN ? BORDER_W : 0;
  localparam logic [10:0] X_LO = 11'(BRD);
  localparam logic [10:0] X_HI = 11'(SCREEN_W - PW - BRD);
  localparam logic [9:0]  Y_LO = 10'(BRD);
  localparam logic [9:0]  Y_HI = 10'(SCREEN_H - PH - BRD);

  state_e      state_q, state_d;
  logic        vs_q, tick, move_en, reload;
  logic [9:0]  px_q, px_d;
  logic [8:0]  py_q, py_d;
  logic [11:0] rgb_q, rgb_d;
  logic        key_make, key_left, key_right, key_up, key_down, key_restart, key_esc;
  logic [10:0] pxe, xe;
  logic [9:0]  pye, ye;
  logic        visible, player_px, in_border, collide_any;
  logic [N_OBST-1:0] hit_v, collide_v;

  assign key_make    = ~keyboard[8] & ~keyboard[9];
  assign key_left    = key_make && (keyboard[7:0] == KEY_LEFT);
  assign key_right   = key_make && (keyboard[7:0] == KEY_RIGHT);
  assign key_up      = key_make && (keyboard[7:0] == KEY_UP);
  assign key_down    = key_make && (keyboard[7:0] == KEY_DOWN);
  assign key_restart = ~keyboard[8] && (keyboard[7:0] == KEY_RESTART);
  assign key_esc     = BORDER_EN && ~keyboard[8] && (keyboard[7:0] == KEY_ESC);

  assign tick = vs & ~vs_q;
  assign pxe  = {1'b0, px_q};
  assign pye  = {1'b0, py_q};
  assign xe   = {1'b0, x};
  assign ye   = {1'b0, y};

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      RUN:     if (collide_any || key_esc) state_d = HALT;
      HALT:    if (key_restart)            state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    move_en = (state_q == RUN) && tick;
    reload  = (state_q == HALT) && key_restart;
    stop    = (state_q == HALT);
  end

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (reload) begin
      px_d = 10'(INIT_X);
      py_d = 9'(INIT_Y);
    end else if (move_en) begin
      if (key_left)       px_d = (pxe >= X_LO + 11'(STEP)) ? px_q - 10'(STEP) : X_LO[9:0];
      else if (key_right) px_d = (pxe + 11'(STEP) <= X_HI) ? px_q + 10'(STEP) : X_HI[9:0];
      if (key_up)         py_d = (pye >= Y_LO + 10'(STEP)) ? py_q - 9'(STEP) : Y_LO[8:0];
      else if (key_down)  py_d = (pye + 10'(STEP) <= Y_HI) ? py_q + 9'(STEP) : Y_HI[8:0];
    end
  end

  for (genvar i = 0; i < N_OBST; i++) begin : g_obst
    obstacle_unit #(
      .IDX(i), .SCREEN_W(SCREEN_W), .OW(OW), .OH(OH), .PW(PW), .PH(PH),
      .OBST_SPEED(OBST_SPEED), .OBST_X0(OBST_X0), .OBST_GAP(OBST_GAP),
      .OBST_Y0(OBST_Y0), .OBST_YSTEP(OBST_YSTEP)
    ) u_obst (
      .clk(clk), .reset(reset), .move_i(move_en), .reload_i(reload),
      .px_i(px_q), .py_i(py_q), .x_i(x), .y_i(y),
      .hit_o(hit_v[i]), .collide_o(collide_v[i])
    );
  end

  assign collide_any = |collide_v;
  assign visible     = (xe < 11'(SCREEN_W)) && (ye < 10'(SCREEN_H));
  assign player_px   = (xe >= pxe) && (xe <= pxe + 11'(PW - 1)) &&
                       (ye >= pye) && (ye <= pye + 10'(PH - 1));
  assign in_border   = BORDER_EN && ((xe < 11'(BORDER_W)) || (xe >= 11'(SCREEN_W - BORDER_W)) ||
                                     (ye < 10'(BORDER_W)) || (ye >= 10'(SCREEN_H - BORDER_W)));

  always_comb begin
    rgb_d = COL_BG;
    if (!visible)      rgb_d = COL_OFF;
    else if (player_px) rgb_d = (state_q == HALT) ? COL_PLAYER_HIT : COL_PLAYER;
    else if (in_border) rgb_d = COL_BORDER;
    else if (|hit_v)    rgb_d = COL_OBST;
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values, independent of statement order.
    if (reset) begin
      vs_q  <= 1'b0;
      px_q  <= 10'(INIT_X);
      py_q  <= 9'(INIT_Y);
      rgb_q <= COL_OFF;
    end else begin
      vs_q  <= vs;
      px_q  <= px_d;
      py_q  <= py_d;
      rgb_q <= rgb_d;
    end
  end

  assign RGB = rgb_q;

endmodule

// File: tb/tb_sprite_field_engine.sv
// Directed self-checking bench for sprite_field_engine with default parameters, macro undefined.
module tb_sprite_field_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vs = 1'b0;
  logic [9:0]  keyboard = 10'h000;
  logic [9:0]  x = 10'd0;
  logic [8:0]  y = 9'd0;
  logic [11:0] RGB;
  logic        stop;

  int checks = 0;
  int failures = 0;

  sprite_field_engine dut (
    .clk(clk), .reset(reset), .vs(vs), .keyboard(keyboard),
    .x(x), .y(y), .RGB(RGB), .stop(stop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; vs = 1'b0; keyboard = 10'h000;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic do_tick();
    vs = 1'b1; step();
    vs = 1'b0; step();
  endtask

  task automatic probe(input logic [9:0] px, input logic [8:0] py, output logic [11:0] c);
    x = px; y = py;
    step();
    c = RGB;
  endtask

  task automatic reach_halt_minus_one();
    apply_reset();
    keyboard = 10'h01D;
    repeat (42) do_tick();
    keyboard = 10'h11D;
    repeat (100) do_tick();
  endtask

  task automatic test_reset();
    logic [11:0] c;
    apply_reset();
    checks++; if (RGB !== 12'h000) begin failures++; $display("FAIL rst_rgb got=%h exp=000", RGB); end
    checks++; if (stop !== 1'b0) begin failures++; $display("FAIL rst_stop got=%b exp=0", stop); end
    checks++; if (dut.px_q !== 10'd20) begin failures++; $display("FAIL rst_px got=%0d exp=20", dut.px_q); end
    checks++; if (dut.py_q !== 9'd232) begin failures++; $display("FAIL rst_py got=%0d exp=232", dut.py_q); end
    probe(10'd20, 9'd232, c);
    checks++; if (c !== 12'h0F0) begin failures++; $display("FAIL rst_player_px got=%h exp=0F0", c); end
    probe(10'd700, 9'd10, c);
    checks++; if (c !== 12'h000) begin failures++; $display("FAIL rst_offscreen_x got=%h exp=000", c); end
    probe(10'd20, 9'd480, c);
    checks++; if (c !== 12'h000) begin failures++; $display("FAIL rst_offscreen_y got=%h exp=000", c); end
    probe(10'd19, 9'd232, c);
    checks++; if (c !== 12'h008) begin failures++; $display("FAIL rst_background got=%h exp=008", c); end
  endtask

  task automatic test_left_clamp();
    int exp_px [6] = '{16, 12, 8, 4, 0, 0};
    apply_reset();
    keyboard = 10'h01C;
    for (int i = 0; i < 6; i++) begin
      do_tick();
      checks++;
      if (dut.px_q !== 10'(exp_px[i])) begin
        failures++; $display("FAIL left_clamp tick%0d got=%0d exp=%0d", i + 1, dut.px_q, exp_px[i]);
      end
    end
    checks++; if (dut.py_q !== 9'd232) begin failures++; $display("FAIL left_py got=%0d exp=232", dut.py_q); end
    keyboard = 10'h000;
  endtask

  task automatic test_obstacles();
    logic [11:0] c;
    apply_reset();
    do_tick();
    probe(10'd318, 9'd64, c);
    checks++; if (c !== 12'hFFF) begin failures++; $display("FAIL obst0_left got=%h exp=FFF", c); end
    probe(10'd317, 9'd64, c);
    checks++; if (c !== 12'h008) begin failures++; $display("FAIL obst0_before got=%h exp=008", c); end
    probe(10'd333, 9'd64, c);
    checks++; if (c !== 12'hFFF) begin failures++; $display("FAIL obst0_right got=%h exp=FFF", c); end
    probe(10'd334, 9'd64, c);
    checks++; if (c !== 12'h008) begin failures++; $display("FAIL obst0_after got=%h exp=008", c); end
    repeat (279) do_tick();
    probe(10'd0, 9'd352, c);
    checks++; if (c !== 12'hFFF) begin failures++; $display("FAIL obst3_at0 got=%h exp=FFF", c); end
    probe(10'd16, 9'd352, c);
    checks++; if (c !== 12'h008) begin failures++; $display("FAIL obst3_at0_edge got=%h exp=008", c); end
    do_tick();
    probe(10'd624, 9'd352, c);
    checks++; if (c !== 12'hFFF) begin failures++; $display("FAIL obst3_wrap got=%h exp=FFF", c); end
    probe(10'd623, 9'd352, c);
    checks++; if (c !== 12'h008) begin failures++; $display("FAIL obst3_wrap_edge got=%h exp=008", c); end
    probe(10'd0, 9'd352, c);
    checks++; if (c !== 12'h008) begin failures++; $display("FAIL obst3_left_clear got=%h exp=008", c); end
  endtask

  task automatic test_collision();
    logic [11:0] c;
    apply_reset();
    keyboard = 10'h01D;
    repeat (42) do_tick();
    checks++; if (dut.py_q !== 9'd64) begin failures++; $display("FAIL up_py got=%0d exp=64", dut.py_q); end
    keyboard = 10'h11D;
    repeat (100) do_tick();
    checks++; if (stop !== 1'b0) begin failures++; $display("FAIL pre_collide_stop got=%b exp=0", stop); end
    do_tick();
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL collide_stop got=%b exp=1", stop); end
    probe(10'd20, 9'd64, c);
    checks++; if (c !== 12'hF00) begin failures++; $display("FAIL halt_player got=%h exp=F00", c); end
    probe(10'd34, 9'd64, c);
    checks++; if (c !== 12'hF00) begin failures++; $display("FAIL halt_overlap got=%h exp=F00", c); end
    do_tick();
    checks++; if (dut.py_q !== 9'd64) begin failures++; $display("FAIL halt_frozen_py got=%0d exp=64", dut.py_q); end
    probe(10'd49, 9'd64, c);
    checks++; if (c !== 12'hFFF) begin failures++; $display("FAIL halt_frozen_obst got=%h exp=FFF", c); end
  endtask

  task automatic test_restart();
    logic [11:0] c;
    keyboard = 10'h129;
    step(); step(); step();
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL break_no_restart got=%b exp=1", stop); end
    keyboard = 10'h029;
    step();
    keyboard = 10'h000;
    checks++; if (stop !== 1'b0) begin failures++; $display("FAIL restart_stop got=%b exp=0", stop); end
    checks++; if (dut.px_q !== 10'd20) begin failures++; $display("FAIL restart_px got=%0d exp=20", dut.px_q); end
    checks++; if (dut.py_q !== 9'd232) begin failures++; $display("FAIL restart_py got=%0d exp=232", dut.py_q); end
    probe(10'd320, 9'd64, c);
    checks++; if (c !== 12'hFFF) begin failures++; $display("FAIL restart_obst0 got=%h exp=FFF", c); end
    probe(10'd319, 9'd64, c);
    checks++; if (c !== 12'h008) begin failures++; $display("FAIL restart_obst0_edge got=%h exp=008", c); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] c;
    reach_halt_minus_one();
    do_tick();
    checks++; if (stop !== 1'b1) begin failures++; $display("FAIL b2b_halt got=%b exp=1", stop); end
    vs = 1'b1; keyboard = 10'h029;
    step();
    vs = 1'b0; keyboard = 10'h000;
    checks++; if (stop !== 1'b0) begin failures++; $display("FAIL b2b_stop got=%b exp=0", stop); end
    checks++; if (dut.py_q !== 9'd232) begin failures++; $display("FAIL b2b_py got=%0d exp=232", dut.py_q); end
    step();
    probe(10'd320, 9'd64, c);
    checks++; if (c !== 12'hFFF) begin failures++; $display("FAIL b2b_obst0 got=%h exp=FFF", c); end
    probe(10'd319, 9'd64, c);
    checks++; if (c !== 12'h008) begin failures++; $display("FAIL b2b_obst0_edge got=%h exp=008", c); end
  endtask

  task automatic test_reset_midop();
    logic [11:0] c;
    apply_reset();
    keyboard = 10'h023;
    repeat (3) do_tick();
    checks++; if (dut.px_q !== 10'd32) begin failures++; $display("FAIL right_px got=%0d exp=32", dut.px_q); end
    vs = 1'b1; reset = 1'b1;
    step();
    vs = 1'b0; reset = 1'b0;
    checks++; if (dut.px_q !== 10'd20) begin failures++; $display("FAIL midop_px got=%0d exp=20", dut.px_q); end
    step(); step();
    checks++; if (dut.px_q !== 10'd20) begin failures++; $display("FAIL midop_no_move got=%0d exp=20", dut.px_q); end
    probe(10'd320, 9'd64, c);
    checks++; if (c !== 12'hFFF) begin failures++; $display("FAIL midop_obst0 got=%h exp=FFF", c); end
    reach_halt_minus_one();
    do_tick();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (stop !== 1'b0) begin failures++; $display("FAIL halt_reset_stop got=%b exp=0", stop); end
    checks++; if (dut.py_q !== 9'd232) begin failures++; $display("FAIL halt_reset_py got=%0d exp=232", dut.py_q); end
  endtask

  initial begin
    step();
    test_reset();
    test_left_clamp();
    test_obstacles();
    test_collision();
    test_restart();
    test_back_to_back();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
